chip8_keypad: RTL and testbench

- Scans a 4x4 CHIP-8 hex matrix keypad, synchronises and debounces each key, and presents a stable 16-bit key vector for the CPU `keys` input.
- Produces a one-cycle key-press event with the hex code, which the CPU uses for FX0A (wait for key).
- Sits between the board keypad pins and chip8_cpu in fpga_chip8.

---
 rtl/chip8_pkg.sv | 27 ++
 rtl/keypad_debounce_cell.sv | 43 ++++
 rtl/chip8_keypad.sv | 116 +++++++++++
 tb/tb_chip8_keypad.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// chip8_pkg : keypad geometry and hex key map shared by the CHIP-8 blocks
// Revision  : 1.0
// ============================================================================
package chip8_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  // Indexed by {row, col}; entry 0 is row0/col0 (hex 1), entry 15 is row3/col3 (hex F).
  localparam logic [NUM_KEYS-1:0][KEY_CODE_W-1:0] KEYMAP = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [KEY_CODE_W-1:0] key_hex(input logic [1:0] row,
                                                    input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce_cell.sv
`default_nettype none
// ============================================================================
// keypad_debounce_cell : per-key counter debouncer, updated only on its sample
// Revision             : 1.0
// ============================================================================
module keypad_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       done;

  assign cnt_inc = cnt + 4'd1;
  assign done    = (raw != stable) && (cnt_inc == 4'(DEBOUNCE_SCANS));
  // Combinational so the top can register the event alongside the new stable value.
  assign rise    = sample_en && done && raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 4'd0;
      stable <= 1'b0;
    end else if (sample_en) begin
      if (raw == stable) begin
        cnt <= 4'd0;
      end else if (done) begin
        stable <= raw;
        cnt    <= 4'd0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chip8_keypad.sv
`default_nettype none
// ============================================================================
// chip8_keypad : 4x4 hex keypad scanner with debounce and key-press events
// Revision     : 1.0
// ============================================================================
module chip8_keypad
  import chip8_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_ROWS-1:0]   row_in,
  output logic [KEY_COLS-1:0]   col_out,
  output logic [NUM_KEYS-1:0]   keys,
  output logic                  any_key,
  output logic                  key_event,
  output logic [KEY_CODE_W-1:0] key_code
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [KEY_ROWS-1:0]   sync_meta;
  logic [KEY_ROWS-1:0]   sync_row;
  logic [KEY_ROWS-1:0]   pressed;
  logic [DIV_W-1:0]      div;
  logic [1:0]            col;
  logic                  sample;
  logic [KEY_COLS-1:0]   sample_col;
  logic [NUM_KEYS-1:0]   stable_pos;
  logic [NUM_KEYS-1:0]   rise_pos;
  logic [NUM_KEYS-1:0]   keys_hex;
  logic [NUM_KEYS-1:0]   rise_hex;
  logic [KEY_CODE_W-1:0] event_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 4'hF;
      sync_row  <= 4'hF;
    end else begin
      sync_meta <= row_in;
      sync_row  <= sync_meta;
    end
  end

  assign pressed = ~sync_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      col     <= col + 2'd1;
      col_out <= ~(4'b0001 << (col + 2'd1));
    end else begin
      div <= div + 1'b1;
    end
  end

  // Rows are read at the end of each slot so the synchroniser has settled on this column.
  assign sample     = (div == DIV_LAST);
  assign sample_col = sample ? (4'b0001 << col) : 4'b0000;

  for (genvar r = 0; r < KEY_ROWS; r++) begin : g_row
    for (genvar c = 0; c < KEY_COLS; c++) begin : g_col
      keypad_debounce_cell #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_cell (
        .clk      (clk),
        .reset    (reset),
        .sample_en(sample_col[c]),
        .raw      (pressed[r]),
        .stable   (stable_pos[r*KEY_COLS + c]),
        .rise     (rise_pos[r*KEY_COLS + c])
      );
    end
  end

  always_comb begin
    keys_hex = '0;
    rise_hex = '0;
    for (int r = 0; r < KEY_ROWS; r++) begin
      for (int c = 0; c < KEY_COLS; c++) begin
        keys_hex[key_hex(2'(r), 2'(c))] = stable_pos[r*KEY_COLS + c];
        rise_hex[key_hex(2'(r), 2'(c))] = rise_pos[r*KEY_COLS + c];
      end
    end
  end

  // Lowest hex value wins when several keys in one column press together.
  always_comb begin
    event_code = '0;
    for (int h = NUM_KEYS - 1; h >= 0; h--) begin
      if (rise_hex[h]) event_code = KEY_CODE_W'(h);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_event <= 1'b0;
      key_code  <= '0;
    end else begin
      key_event <= |rise_hex;
      if (|rise_hex) key_code <= event_code;
    end
  end

  assign keys    = keys_hex;
  assign any_key = |keys_hex;

endmodule
`default_nettype wire

// File: tb/tb_chip8_keypad.sv
`default_nettype none
// ============================================================================
// tb_chip8_keypad : directed self-checking bench with a behavioural keypad matrix
// Revision        : 1.0
// ============================================================================
module tb_chip8_keypad;

  logic        clk;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        any_key;
  logic        key_event;
  logic [3:0]  key_code;

  logic [15:0] held;
  logic [3:0]  hexmap [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                               4'h4, 4'h5, 4'h6, 4'hD,
                               4'h7, 4'h8, 4'h9, 4'hE,
                               4'hA, 4'h0, 4'hB, 4'hF};
  int          n_checks;
  int          n_fail;
  int          ev_total;
  logic [3:0]  ev_last_code;

  chip8_keypad #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .keys     (keys),
    .any_key  (any_key),
    .key_event(key_event),
    .key_code (key_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Closed switch pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[hexmap[r*4 + c]] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_event === 1'b1) begin
      ev_total     = ev_total + 1;
      ev_last_code = key_code;
    end
  end

  task automatic test_reset();
    logic [3:0] exp_col;
    held  = 16'h0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col_out: got %b expected 1110", col_out); end
    n_checks++;
    if (keys !== 16'h0000) begin n_fail++; $display("FAIL reset_keys: got %h expected 0000", keys); end
    n_checks++;
    if (key_event !== 1'b0) begin n_fail++; $display("FAIL reset_key_event: got %b expected 0", key_event); end
    n_checks++;
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
    n_checks++;
    if (any_key !== 1'b0) begin n_fail++; $display("FAIL reset_any_key: got %b expected 0", any_key); end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_checks++;
      if (col_out !== exp_col) begin
        n_fail++;
        $display("FAIL scan_col_out cycle %0d: got %b expected %b", k, col_out, exp_col);
      end
    end
  endtask

  task automatic test_single_press();
    int waited;
    int ev0;
    ev0    = ev_total;
    held   = 16'h0040;
    waited = 0;
    while (keys !== 16'h0040 && waited < 51) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (keys !== 16'h0040) begin n_fail++; $display("FAIL press_keys: got %h expected 0040 within 51 cycles", keys); end
    n_checks++;
    if (any_key !== 1'b1) begin n_fail++; $display("FAIL press_any_key: got %b expected 1", any_key); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (ev_total - ev0 !== 1) begin n_fail++; $display("FAIL press_event_count: got %0d expected 1", ev_total - ev0); end
    n_checks++;
    if (ev_last_code !== 4'h6) begin n_fail++; $display("FAIL press_event_code: got %h expected 6", ev_last_code); end
    n_checks++;
    if (key_code !== 4'h6) begin n_fail++; $display("FAIL press_key_code: got %h expected 6", key_code); end
  endtask

  task automatic test_release();
    int waited;
    int ev0;
    ev0    = ev_total;
    held   = 16'h0000;
    waited = 0;
    while (keys !== 16'h0000 && waited < 51) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (keys !== 16'h0000) begin n_fail++; $display("FAIL release_keys: got %h expected 0000 within 51 cycles", keys); end
    n_checks++;
    if (any_key !== 1'b0) begin n_fail++; $display("FAIL release_any_key: got %b expected 0", any_key); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (ev_total - ev0 !== 0) begin n_fail++; $display("FAIL release_event_count: got %0d expected 0", ev_total - ev0); end
    n_checks++;
    if (key_code !== 4'h6) begin n_fail++; $display("FAIL release_key_code: got %h expected 6", key_code); end
  endtask

  task automatic test_bounce();
    logic [15:0] seen;
    int          ev0;
    ev0  = ev_total;
    seen = 16'h0000;
    for (int s = 0; s < 10; s++) begin
      held = (s % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (16) begin
        @(negedge clk);
        seen = seen | keys;
      end
    end
    held = 16'h0000;
    repeat (48) begin
      @(negedge clk);
      seen = seen | keys;
    end
    n_checks++;
    if (seen !== 16'h0000) begin n_fail++; $display("FAIL bounce_keys: got %h expected 0000", seen); end
    n_checks++;
    if (ev_total - ev0 !== 0) begin n_fail++; $display("FAIL bounce_event_count: got %0d expected 0", ev_total - ev0); end
  endtask

  task automatic test_simultaneous();
    int waited;
    int ev0;
    ev0    = ev_total;
    held   = 16'h0012;
    waited = 0;
    while (keys !== 16'h0012 && waited < 51) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (keys !== 16'h0012) begin n_fail++; $display("FAIL simul_keys: got %h expected 0012 within 51 cycles", keys); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (ev_total - ev0 !== 1) begin n_fail++; $display("FAIL simul_event_count: got %0d expected 1", ev_total - ev0); end
    n_checks++;
    if (key_code !== 4'h1) begin n_fail++; $display("FAIL simul_key_code: got %h expected 1", key_code); end
    held   = 16'h0000;
    waited = 0;
    while (keys !== 16'h0000 && waited < 51) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (keys !== 16'h0000) begin n_fail++; $display("FAIL simul_release_keys: got %h expected 0000", keys); end
  endtask

  // Hex F is sampled at edges 16 and 32 after a reset release; the reset lands before edge 48.
  task automatic test_reset_mid_debounce();
    int ev0;
    held  = 16'h0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    held  = 16'h8000;
    reset = 1'b0;
    repeat (33) @(negedge clk);
    n_checks++;
    if (keys !== 16'h0000) begin n_fail++; $display("FAIL mid_pre_reset_keys: got %h expected 0000", keys); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL mid_reset_key_code: got %h expected 0", key_code); end
    n_checks++;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL mid_reset_col_out: got %b expected 1110", col_out); end
    ev0   = ev_total;
    reset = 1'b0;
    repeat (47) @(negedge clk);
    n_checks++;
    if (keys !== 16'h0000) begin n_fail++; $display("FAIL mid_before_third_sample_keys: got %h expected 0000", keys); end
    @(negedge clk);
    n_checks++;
    if (keys !== 16'h8000) begin n_fail++; $display("FAIL mid_after_third_sample_keys: got %h expected 8000", keys); end
    n_checks++;
    if (key_event !== 1'b1) begin n_fail++; $display("FAIL mid_key_event: got %b expected 1", key_event); end
    n_checks++;
    if (key_code !== 4'hF) begin n_fail++; $display("FAIL mid_key_code: got %h expected f", key_code); end
    n_checks++;
    if (any_key !== 1'b1) begin n_fail++; $display("FAIL mid_any_key: got %b expected 1", any_key); end
    @(negedge clk);
    n_checks++;
    if (key_event !== 1'b0) begin n_fail++; $display("FAIL mid_event_width: got %b expected 0", key_event); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (ev_total - ev0 !== 1) begin n_fail++; $display("FAIL mid_event_count: got %0d expected 1", ev_total - ev0); end
    held = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, n_checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    ev_total     = 0;
    ev_last_code = 4'h0;
    held         = 16'h0000;
    reset        = 1'b1;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
